// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;
  localparam int unsigned ALU_W   = 16;
  localparam int unsigned ALU_OPW = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  localparam logic [ALU_OPW-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] ALU_OP_AND = 3'b010;
  localparam logic [ALU_OPW-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [ALU_OPW-1:0] ALU_OP_XOR = 3'b100;
  localparam logic [ALU_OPW-1:0] ALU_OP_SHL = 3'b101;
  localparam logic [ALU_OPW-1:0] ALU_OP_SHR = 3'b110;
  localparam logic [ALU_OPW-1:0] ALU_OP_SLT = 3'b111;
endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the issue logic (master) and alu_share_arb (slave).
interface alu_share_arb_if import alu_arb_pkg::*; #(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned OPW   = ALU_OPW
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             busy;

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/alu_share_arb_alu.sv
// Shared combinational ALU; zeroOutput flags an all-zero result.
module ALU import alu_arb_pkg::*; #(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [OPW-1:0]   opCode,
  output logic [WIDTH-1:0] outputALU,
  output logic             zeroOutput
);
  always_comb begin
    outputALU = '0;
    case (opCode)
      ALU_OP_ADD: outputALU = input1 + input2;
      ALU_OP_SUB: outputALU = input1 - input2;
      ALU_OP_AND: outputALU = input1 & input2;
      ALU_OP_OR:  outputALU = input1 | input2;
      ALU_OP_XOR: outputALU = input1 ^ input2;
      ALU_OP_SHL: outputALU = input1 << 1;
      ALU_OP_SHR: outputALU = input1 >> 1;
      ALU_OP_SLT: outputALU = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      default:    outputALU = '0;
    endcase
  end

  assign zeroOutput = (outputALU == '0);
endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one registered ALU operation at a time.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_arb import alu_arb_pkg::*; #(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned OPW   = ALU_OPW
) (
  input logic           clk,
  input logic           rst,
  alu_share_arb_if.slave bus
);
  arb_state_t       state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, alu_out;
  logic [OPW-1:0]   op_code;
  logic             alu_zero;
  logic             owner;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;

  function automatic logic [1:0] arb_pick(input logic [1:0] valid, input logic last);
    logic prefer0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    // last_grant is still tracked, but a tie always goes to requester 0
    prefer0 = 1'b1 | last;
`else
    prefer0 = last;
`endif
    if (valid == 2'b11) return prefer0 ? 2'b01 : 2'b10;
    return valid;
  endfunction

  always_comb begin
    state_nxt = state;
    grant     = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        grant  = rst ? 2'b00 : arb_pick(bus.req_valid, last_grant);
        accept = |grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      op_code        <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant[1];
        last_grant <= grant[1];
        op_a       <= grant[1] ? bus.req1_a  : bus.req0_a;
        op_b       <= grant[1] ? bus.req1_b  : bus.req0_b;
        op_code    <= grant[1] ? bus.req1_op : bus.req0_op;
      end
      if (state == EXEC) begin
        bus.rsp_result <= alu_out;
        bus.rsp_zero   <= alu_zero;
      end
    end
  end

  ALU #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .input1    (op_a),
    .input2    (op_b),
    .opCode    (op_code),
    .outputALU (alu_out),
    .zeroOutput(alu_zero)
  );

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy      = (state != IDLE);
endmodule
